// File: rtl/reset_sequencer.sv
// Button/power-on reset sequencer: holds every stage in reset, then releases the
// stages one at a time, bit 0 first, waiting for each acknowledge (with a timeout).
module reset_sequencer #(
  parameter int HOLD_CYCLES   = 10,
  parameter int ASSERT_CYCLES = 4,
  parameter int NUM_STAGES    = 3,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Btn_L,
  input  logic [NUM_STAGES-1:0] Stage_Ack,
  output logic [NUM_STAGES-1:0] Stage_Reset_L,
  output logic                  Seq_Busy,
  output logic                  Seq_Done,
  output logic                  Ack_Timeout
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [15:0]      HOLD_MAX   = 16'(HOLD_CYCLES);
  localparam logic [15:0]      ASSERT_MAX = 16'(ASSERT_CYCLES);
  localparam logic [15:0]      ACK_MAX    = 16'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e           state_q;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_inc;
  logic [IDX_W-1:0] idx_q;
  logic             sync1_q;
  logic             btn_s_q;
  logic             ack_now;

  // Stages 0..idx are out of reset, the rest are held.
  function automatic logic [NUM_STAGES-1:0] released_mask(input logic [IDX_W-1:0] idx);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      m[i] = (i <= int'(idx));
    end
    return m;
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      btn_s_q <= 1'b1;
    end else begin
      sync1_q <= Btn_L;
      btn_s_q <= sync1_q;
    end
  end

  // The one counter serves as hold, assert and ack-wait counter; it never wraps.
  always_comb begin
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    ack_now = Stage_Ack[idx_q];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_ASSERT;
      cnt_q         <= 16'd0;
      idx_q         <= '0;
      Stage_Reset_L <= '0;
      Seq_Busy      <= 1'b1;
      Seq_Done      <= 1'b0;
      Ack_Timeout   <= 1'b0;
    end else begin
      Seq_Done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!btn_s_q) begin
            state_q <= S_ARM;
            cnt_q   <= 16'd1;
          end else begin
            cnt_q <= 16'd0;
          end
        end
        S_ARM: begin
          if (!btn_s_q) begin
            if (cnt_q < HOLD_MAX) cnt_q <= cnt_inc;
          end else if (cnt_q >= HOLD_MAX) begin
            state_q       <= S_ASSERT;
            cnt_q         <= 16'd0;
            Stage_Reset_L <= '0;
            Seq_Busy      <= 1'b1;
            Ack_Timeout   <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
          end
        end
        S_ASSERT: begin
          if (cnt_inc >= ASSERT_MAX) begin
            state_q       <= S_RELEASE;
            cnt_q         <= 16'd0;
            idx_q         <= '0;
            Stage_Reset_L <= released_mask('0);
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RELEASE: begin
          // An ack arriving on the timeout cycle wins, so no flag is raised.
          if (ack_now || (cnt_inc >= ACK_MAX)) begin
            if (!ack_now) Ack_Timeout <= 1'b1;
            cnt_q <= 16'd0;
            if (idx_q == LAST_IDX) begin
              state_q       <= S_DONE;
              Seq_Done      <= 1'b1;
              Stage_Reset_L <= '1;
            end else begin
              idx_q         <= idx_q + IDX_W'(1);
              Stage_Reset_L <= released_mask(idx_q + IDX_W'(1));
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          cnt_q    <= 16'd0;
          Seq_Busy <= 1'b0;
        end
        default: begin
          state_q       <= S_ASSERT;
          cnt_q         <= 16'd0;
          idx_q         <= '0;
          Stage_Reset_L <= '0;
          Seq_Busy      <= 1'b1;
          Ack_Timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule
